// File: rtl/bus_arbit_pkg.sv
// Shared definitions for the N-master bus arbiter: mode codes, FSM encoding
// and a one-hot to index helper.
package bus_arbit_pkg;

    localparam int unsigned MODE_FIXED  = 0;
    localparam int unsigned MODE_RR     = 1;
    localparam int unsigned MAX_MASTERS = 16;

    typedef enum logic {
        PARK = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Valid only for a one-hot (or zero) input; bits are OR-ed, not prioritised.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] i_oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (i_oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: lowest index (fixed) or first set bit at or
// above the rotating pointer, wrapping at N_MASTERS-1 (round-robin).
module arb_pick
    import bus_arbit_pkg::*;
#(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned MODE      = MODE_RR,
    localparam int unsigned PW       = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] i_cand,
    input  logic [PW-1:0]        i_rr_ptr,
    output logic [PW-1:0]        o_winner,
    output logic                 o_any
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = (MODE == MODE_RR) ? i_rr_ptr : '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!o_any && i_cand[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
            w_idx = (w_idx == PW'(N_MASTERS - 1)) ? '0 : w_idx + PW'(1);
        end
    end

endmodule

// File: rtl/bus_arbit_rr.sv
// N-master bus arbiter with fixed or round-robin priority, a hold limit that
// forces rotation under contention, and parking on master 0 when idle.
module bus_arbit_rr
    import bus_arbit_pkg::*;
#(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned MODE      = MODE_RR,
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned ID_W      = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_valid
);

    localparam int unsigned PW = $clog2(N_MASTERS);
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [N_MASTERS-1:0] GRANT_PARK = {{(N_MASTERS-1){1'b0}}, 1'b1};

    arb_state_e             r_state, w_state_d;
    logic [N_MASTERS-1:0]   r_grant, w_grant_d;
    logic [HW-1:0]          r_hold, w_hold_d;
    logic [PW-1:0]          r_ptr, w_ptr_d;

    logic [N_MASTERS-1:0]   w_others;
    logic                   w_own_req;
    logic                   w_force;
    logic [N_MASTERS-1:0]   w_cand;
    logic [PW-1:0]          w_winner;
    logic                   w_any;
    logic                   w_take;
    logic [MAX_MASTERS-1:0] w_grant_ext;

    assign w_others  = req & ~r_grant;
    assign w_own_req = |(req & r_grant);
    assign w_force   = (r_state == OWN) && w_own_req && (|w_others) &&
                       (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
    // Forced rotation must not re-pick the owner, so mask it out of the candidates.
    assign w_cand    = w_force ? w_others : req;

    arb_pick #(
        .N_MASTERS (N_MASTERS),
        .MODE      (MODE)
    ) u_pick (
        .i_cand    (w_cand),
        .i_rr_ptr  (r_ptr),
        .o_winner  (w_winner),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_hold_d  = r_hold;
        w_ptr_d   = r_ptr;
        w_take    = 1'b0;
        case (r_state)
            PARK: begin
                w_take = w_any;
            end
            OWN: begin
                if (w_own_req) begin
                    if (w_force) begin
                        w_take = 1'b1;
                    end else if (r_hold != HOLD_LAST) begin
                        w_hold_d = r_hold + HW'(1);
                    end
                end else if (w_any) begin
                    w_take = 1'b1;
                end else begin
                    w_state_d = PARK;
                    w_grant_d = GRANT_PARK;
                    w_hold_d  = '0;
                end
            end
            default: begin
                w_state_d = PARK;
                w_grant_d = GRANT_PARK;
                w_hold_d  = '0;
            end
        endcase
        if (w_take) begin
            w_state_d = OWN;
            w_grant_d = GRANT_PARK << w_winner;
            w_hold_d  = '0;
            w_ptr_d   = (w_winner == PW'(N_MASTERS - 1)) ? '0 : w_winner + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= PARK;
            r_grant <= GRANT_PARK;
            r_hold  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_hold  <= w_hold_d;
            r_ptr   <= w_ptr_d;
        end
    end

    assign w_grant_ext = MAX_MASTERS'(r_grant);
    assign grant       = r_grant;
    assign grant_id    = ID_W'(onehot_to_idx(w_grant_ext));
    assign grant_valid = (r_state == OWN);

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Directed bench for bus_arbit_rr: three instances (round-robin unlimited hold,
// fixed priority, round-robin with hold limit 4) checked against a scoreboard.
module tb_bus_arbit_rr;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] grant_a, grant_b, grant_c;
    logic [1:0] id_a, id_b, id_c;
    logic       valid_a, valid_b, valid_c;

    always #5 clk = ~clk;

    bus_arbit_rr #(.N_MASTERS(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .req(req_a),
        .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a)
    );

    bus_arbit_rr #(.N_MASTERS(4), .MODE(0), .MAX_HOLD(16)) u_fix (
        .clk(clk), .reset_n(reset_n), .req(req_b),
        .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b)
    );

    bus_arbit_rr #(.N_MASTERS(4), .MODE(1), .MAX_HOLD(4)) u_hold (
        .clk(clk), .reset_n(reset_n), .req(req_c),
        .grant(grant_c), .grant_id(id_c), .grant_valid(valid_c)
    );

    typedef struct {
        string      tag;
        int         dut;
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_grant(input string tag, input int dut, input logic [3:0] g,
                                input logic v);
        exp_t e;
        e.tag   = tag;
        e.dut   = dut;
        e.grant = g;
        e.valid = v;
        e.id    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) e.id = 2'(i);
        end
        sb.push_back(e);
    endtask

    task automatic expect_all(input string tag, input logic [3:0] g, input logic v);
        for (int d = 0; d < 3; d++) expect_grant(tag, d, g, v);
    endtask

    task automatic tick();
        exp_t       e;
        logic [3:0] og;
        logic [1:0] oid;
        logic       ov;
        @(posedge clk);
        #1;
        checks++;
        assert ($onehot(grant_a) && $onehot(grant_b) && $onehot(grant_c)) else begin
            failures++;
            $error("FAIL onehot got=%b/%b/%b exp=one bit set each", grant_a, grant_b, grant_c);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin og = grant_a; oid = id_a; ov = valid_a; end
                1:       begin og = grant_b; oid = id_b; ov = valid_b; end
                default: begin og = grant_c; oid = id_c; ov = valid_c; end
            endcase
            checks++;
            assert (og === e.grant) else begin
                failures++;
                $error("FAIL %s dut%0d grant got=%b exp=%b", e.tag, e.dut, og, e.grant);
            end
            checks++;
            assert (oid === e.id) else begin
                failures++;
                $error("FAIL %s dut%0d grant_id got=%0d exp=%0d", e.tag, e.dut, oid, e.id);
            end
            checks++;
            assert (ov === e.valid) else begin
                failures++;
                $error("FAIL %s dut%0d grant_valid got=%b exp=%b", e.tag, e.dut, ov, e.valid);
            end
        end
    endtask

    initial begin
        logic [3:0] rr_seq [4];
        logic [3:0] prev;
        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset held with all requests high, then idle.
        reset_n = 1'b0;
        req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            expect_all("rst_hold", 4'b0001, 1'b0);
            tick();
        end
        reset_n = 1'b1;
        req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            expect_all("idle_park", 4'b0001, 1'b0);
            tick();
        end

        // Hold limit 4: master 0 keeps 4 cycles, then 3 without a bubble, then back.
        req_c = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            expect_grant("hold_own0", 2, 4'b0001, 1'b1);
            tick();
        end
        expect_grant("hold_rot3", 2, 4'b1000, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_grant("hold_keep3", 2, 4'b1000, 1'b1);
            tick();
        end
        expect_grant("hold_rot0", 2, 4'b0001, 1'b1);
        tick();
        req_c = 4'b0000;
        expect_grant("hold_park", 2, 4'b0001, 1'b0);
        tick();

        // Single requester.
        req_c = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            expect_grant("single", 2, 4'b0100, 1'b1);
            tick();
        end
        req_c = 4'b0000;
        expect_grant("single_drop", 2, 4'b0001, 1'b0);
        tick();

        // Round-robin fairness: owner drops its request for one cycle at each grant.
        req_a = 4'b1111;
        expect_grant("rr_first", 0, 4'b0001, 1'b1);
        tick();
        prev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            req_a = 4'b1111 & ~prev;
            expect_grant("rr_seq", 0, rr_seq[i], 1'b1);
            tick();
            prev = rr_seq[i];
        end
        req_a = 4'b0000;
        expect_grant("rr_park", 0, 4'b0001, 1'b0);
        tick();

        // Fixed priority: owner 2 drops, lowest remaining index wins.
        req_b = 4'b0100;
        expect_grant("fix_own2", 1, 4'b0100, 1'b1);
        tick();
        req_b = 4'b1010;
        expect_grant("fix_pick1", 1, 4'b0010, 1'b1);
        tick();
        expect_grant("fix_keep1", 1, 4'b0010, 1'b1);
        tick();
        req_b = 4'b1000;
        expect_grant("fix_next3", 1, 4'b1000, 1'b1);
        tick();
        req_b = 4'b0000;
        expect_grant("fix_park", 1, 4'b0001, 1'b0);
        tick();

        // Reset mid-burst with master 1 owning (hold reaches 2), then pointer check.
        req_c = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            expect_grant("mid_own1", 2, 4'b0010, 1'b1);
            tick();
        end
        reset_n = 1'b0;
        expect_all("mid_rst", 4'b0001, 1'b0);
        tick();
        reset_n = 1'b1;
        req_c = 4'b1111;
        expect_grant("rst_ptr0", 2, 4'b0001, 1'b1);
        tick();
        req_c = 4'b1110;
        expect_grant("rst_ptr1", 2, 4'b0010, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbit_rr.md
Name:
bus_arbit_rr

Overview:
- Parametrised N-master bus arbiter; successor to the two-master M0/M1 arbiter.
- Sits between the N bus masters and the shared bus mux/decoder. Drives a registered one-hot grant plus an encoded owner id.
- Adds three things the two-master version lacks: selectable fixed-priority or round-robin arbitration, a hold limit that forces rotation under contention, and an explicit grant-valid flag.
- Parks on master 0 when the bus is idle.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_HOLD, 16, maximum consecutive grant cycles while another master is requesting; 0 disables preemption.
- ID_W, $clog2(N_MASTERS), width of grant_id.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req  in  N_MASTERS  request vector, bit i = master i.
- grant  out  N_MASTERS  registered one-hot grant.
- grant_id  out  ID_W  index of the granted or parked master.
- grant_valid  out  1  1 = grant is to a requesting owner; 0 = parked/idle.

Behaviour:
- Single clock. Reset is synchronous and active-low: sampled on the rising clk edge, no asynchronous term.
- Reset values:
  - state = PARK, grant = 1 (master 0), grant_id = 0, grant_valid = 0.
  - hold_cnt = 0, rr_ptr = 0.
  - reset_n low mid-burst returns all of these at the next edge, regardless of req.
- States: PARK (no owner, grant parked on master 0) and OWN (owner = grant_id).
- All outputs are registered. Latency is 1 cycle from req sampled to grant/grant_valid.
- Winner selection ("pick"):
  - MODE 0: lowest set index of the candidate vector.
  - MODE 1: first set bit searching upward from rr_ptr, wrapping N_MASTERS-1 -> 0.
- PARK:
  - req == 0: stay in PARK; grant stays on master 0, valid = 0.
  - req != 0: pick from req; next edge grant = winner, valid = 1, hold_cnt = 0, go to OWN.
- OWN, owner request still high:
  - No other request: keep owner; hold_cnt saturates at MAX_HOLD-1.
  - Other request present and (MAX_HOLD == 0 or hold_cnt < MAX_HOLD-1): keep owner, hold_cnt++.
  - Other request present and hold_cnt == MAX_HOLD-1: forced rotation. Pick from req with the owner bit masked; switch at the next edge; hold_cnt = 0.
- OWN, owner request dropped:
  - Others requesting: pick from req and switch directly at the next edge, with no idle bubble.
  - No requests: go to PARK at the next edge (grant master 0, valid 0).
- rr_ptr: on every new grant, rr_ptr = (winner + 1) mod N_MASTERS, wrapping correctly for non-power-of-2 N. It is unused in MODE 0 but still maintained.
- Simultaneous requests from all masters: exactly one grant bit is set in every cycle, never zero and never more than one.
- grant_id always equals the index of the set grant bit.
- A master that newly raises req in the same cycle that the owner drops it competes normally in that cycle's pick.
- Forced rotation to a master is independent of whether the owner keeps requesting; the old owner re-competes later under the normal rules.
- MAX_HOLD == 1: with contention, the owner switches every cycle.
- req bits are assumed synchronous to clk; no metastability handling inside the block.

Decomposition:
- Package bus_arbit_pkg:
  - MODE_FIXED = 0 and MODE_RR = 1.
  - State encoding PARK = 1'b0, OWN = 1'b1.
  - Function for one-hot to index conversion.
- One sub-module, arb_pick:
  - Purely combinational rotating priority encoder.
  - Parameters N_MASTERS and MODE.
  - Inputs: candidate vector, rr_ptr.
  - Outputs: winner index, any-valid flag.
  - Instantiated once; its candidate input is muxed between req and req with the owner masked.

Test Plan:
1. Reset and idle: reset_n = 0 for 2 cycles with req = 4'b1111, then release with req = 0 -> grant = 4'b0001, grant_id = 0, grant_valid = 0 throughout.
2. Single request: req = 4'b0100 for 5 cycles -> one cycle later grant = 4'b0100, grant_id = 2, valid = 1. When req drops to 0, return to grant = 4'b0001, valid = 0 one cycle later.
3. Round-robin fairness (MODE 1, MAX_HOLD = 0): req = 4'b1111, owner drops and re-asserts req for one cycle at each grant -> grant sequence 0, 1, 2, 3, 0.
4. Fixed priority (MODE 0): owner 2 active, then req = 4'b1110 with bit 2 dropping -> next grant = master 1, not 3.
5. Hold limit (MODE 1, MAX_HOLD = 4): master 0 holds req while master 3 requests from the start -> master 0 granted exactly 4 cycles, then grant = 4'b1000 with no idle cycle between.
6. Reset mid-burst: master 1 owns the bus with hold_cnt = 2 and reset_n is pulsed low for 1 cycle -> next edge grant = 4'b0001, valid = 0, and rr_ptr = 0 (verified by a subsequent req = 4'b1111 granting master 0 first).
